// File: rtl/serial_link_pkg.sv
// Shared constants and types for the board-to-board serial status link.
package serial_link_pkg;

  localparam int unsigned WORD_W = 21;

  localparam logic [4:0] TYPE_FRE   = 5'b00010;
  localparam logic [4:0] TYPE_VOLT  = 5'b00001;
  localparam logic [4:0] TYPE_STATE = 5'b00100;
  localparam logic [4:0] TYPE_FAULT = 5'b00101;

  localparam logic [15:0] FAULT_PAYLOAD = 16'hE5E5;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StDone
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous line plus a falling-edge detector.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // Flops reset high so the idle line never produces a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rxd;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxd_s = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/serial_recv.sv
// Receive side of the serial status link: frames, checks and de-duplicates
// repeated words, publishing data after two matching copies.
module serial_recv
  import serial_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_PT    = 4,
  parameter int unsigned REPEAT_TMO   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        fault_clr,
  output logic [15:0] fre_data,
  output logic [15:0] volt,
  output logic [15:0] state,
  output logic        fre_vld,
  output logic        volt_vld,
  output logic        state_vld,
  output logic        fault_det,
  output logic        fault_flag,
  output logic        parity_err,
  output logic        frame_err,
  output logic        type_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + SAMPLE_PT + 1);
  localparam int unsigned GapW = $clog2(REPEAT_TMO + 1);

  logic rxd_s, fall;

  rx_sync u_rx_sync (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  rx_state_e         state_q;
  logic [CntW-1:0]   cell_cnt_q;
  logic [4:0]        bit_cnt_q;
  logic [WORD_W-1:0] shift_q;
  logic              par_q;
  logic [WORD_W-1:0] last_word_q;
  logic              published_q;
  logic [GapW-1:0]   gap_q;

  logic [4:0]  word_type;
  logic [15:0] payload;
  logic        par_ok, is_fault, type_ok, match;

  assign word_type = shift_q[20:16];
  assign payload   = shift_q[15:0];
  assign par_ok    = ^{shift_q, par_q};
  assign is_fault  = (word_type == TYPE_FAULT) && (payload == FAULT_PAYLOAD);
  assign type_ok   = is_fault || (word_type == TYPE_FRE) || (word_type == TYPE_VOLT) ||
                     (word_type == TYPE_STATE);
  assign match     = (gap_q != '0) && (shift_q == last_word_q);

  // Framing FSM, repeat tracker and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cell_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      last_word_q <= '0;
      published_q <= 1'b0;
      gap_q       <= '0;
      fre_data    <= '0;
      volt        <= '0;
      state       <= '0;
      fre_vld     <= 1'b0;
      volt_vld    <= 1'b0;
      state_vld   <= 1'b0;
      fault_det   <= 1'b0;
      fault_flag  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      type_err    <= 1'b0;
    end else begin
      fre_vld    <= 1'b0;
      volt_vld   <= 1'b0;
      state_vld  <= 1'b0;
      fault_det  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      type_err   <= 1'b0;
      if (fault_clr) fault_flag <= 1'b0;

      // The gap timer only runs while the line is idle, so it measures the
      // time until the next copy starts rather than until it completes.
      if (state_q == StIdle && gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
        if (gap_q == GapW'(1)) begin
          last_word_q <= '0;
          published_q <= 1'b0;
        end
      end

      if (state_q != StIdle && cell_cnt_q != '0) cell_cnt_q <= cell_cnt_q - 1'b1;

      case (state_q)
        StIdle: begin
          if (fall) begin
            cell_cnt_q <= CntW'(SAMPLE_PT - 1);
            bit_cnt_q  <= '0;
            state_q    <= StData;
          end
        end
        StData: begin
          if (cell_cnt_q == '0) begin
            cell_cnt_q <= CntW'(CLKS_PER_BIT - 1);
            shift_q    <= {shift_q[WORD_W-2:0], rxd_s};
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == '0 && rxd_s) state_q <= StIdle;
            else if (bit_cnt_q == 5'(WORD_W - 1)) state_q <= StParity;
          end
        end
        StParity: begin
          if (cell_cnt_q == '0) begin
            cell_cnt_q <= CntW'(CLKS_PER_BIT - 1);
            par_q      <= rxd_s;
            state_q    <= StStop;
          end
        end
        StStop: begin
          if (cell_cnt_q == '0) begin
            if (!rxd_s) begin
              frame_err <= 1'b1;
              state_q   <= StIdle;
            end else begin
              state_q   <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          if (!par_ok) begin
            parity_err <= 1'b1;
          end else if (!type_ok) begin
            type_err <= 1'b1;
          end else begin
            gap_q <= GapW'(REPEAT_TMO);
            if (is_fault) begin
              // Faults act on the first copy; later copies of the burst are absorbed.
              if (!(match && published_q)) begin
                fault_det  <= 1'b1;
                fault_flag <= 1'b1;
              end
              last_word_q <= shift_q;
              published_q <= 1'b1;
            end else if (match) begin
              if (!published_q) begin
                unique case (word_type)
                  TYPE_FRE:   begin fre_data <= payload; fre_vld   <= 1'b1; end
                  TYPE_VOLT:  begin volt     <= payload; volt_vld  <= 1'b1; end
                  default:    begin state    <= payload; state_vld <= 1'b1; end
                endcase
              end
              published_q <= 1'b1;
            end else begin
              last_word_q <= shift_q;
              published_q <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_recv.sv
// Scoreboard bench for serial_recv: expected pulses are queued as stimulus is
// sent and consumed by a monitor when the DUT pulses.
module tb_serial_recv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        fault_clr = 1'b0;
  logic [15:0] fre_data, volt, state;
  logic        fre_vld, volt_vld, state_vld, fault_det, fault_flag;
  logic        parity_err, frame_err, type_err;

  always #5 clk = ~clk;

  serial_recv dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .fault_clr  (fault_clr),
    .fre_data   (fre_data),
    .volt       (volt),
    .state      (state),
    .fre_vld    (fre_vld),
    .volt_vld   (volt_vld),
    .state_vld  (state_vld),
    .fault_det  (fault_det),
    .fault_flag (fault_flag),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .type_err   (type_err)
  );

  // Pulse vector bit positions.
  localparam logic [6:0] EvFre   = 7'b1000000;
  localparam logic [6:0] EvVolt  = 7'b0100000;
  localparam logic [6:0] EvState = 7'b0010000;
  localparam logic [6:0] EvFault = 7'b0001000;
  localparam logic [6:0] EvPar   = 7'b0000100;
  localparam logic [6:0] EvFrame = 7'b0000010;
  localparam logic [6:0] EvType  = 7'b0000001;

  typedef struct packed {
    logic [6:0]  vec;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passed = 0;

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [6:0]  obs_vec;
    logic [15:0] obs_data;
    ev_t         e;
    obs_vec  = {fre_vld, volt_vld, state_vld, fault_det, parity_err, frame_err, type_err};
    obs_data = fre_vld ? fre_data : volt_vld ? volt : state_vld ? state : 16'h0;
    if (!rst && obs_vec != 7'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got vec=%b data=%h, required none", obs_vec, obs_data);
      end else begin
        e = exp_q.pop_front();
        if (obs_vec !== e.vec || obs_data !== e.data)
          $display("FAIL pulse: got vec=%b data=%h, required vec=%b data=%h",
                   obs_vec, obs_data, e.vec, e.data);
        else passed++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_cell(input logic v);
    rxd = v;
    cycles(8);
  endtask

  // One framed copy followed by a 3-cell idle gap.
  task automatic send_word(input logic [4:0] typ, input logic [15:0] pl,
                           input logic bad_par, input logic bad_stop);
    logic [20:0] w;
    logic        par;
    w   = {typ, pl};
    par = ~(^w) ^ bad_par;
    for (int i = 20; i >= 0; i--) drive_cell(w[i]);
    drive_cell(par);
    drive_cell(~bad_stop);
    for (int i = 0; i < 3; i++) drive_cell(1'b1);
  endtask

  task automatic push_ev(input logic [6:0] vec, input logic [15:0] data);
    ev_t e;
    e.vec  = vec;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Let pending pulses drain and the repeat tracker expire, then demand an empty queue.
  task automatic settle(input string name);
    cycles(150);
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_missing: got %0d outstanding expected pulses, required 0",
               name, exp_q.size());
      exp_q.delete();
    end else passed++;
  endtask

  task automatic check_quiet(input string name);
    logic [54:0] outs;
    outs = {fre_data, volt, state, fre_vld, volt_vld, state_vld, fault_det, fault_flag,
            parity_err, frame_err, type_err};
    checks++;
    if (outs !== 55'h0) $display("FAIL %s: got outputs=%h, required 0", name, outs);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(4);
    check_quiet("reset_state");
    rst = 1'b0;
    cycles(20);
  endtask

  task automatic test_volt_burst();
    send_word(5'b00001, 16'h1234, 1'b0, 1'b0);
    push_ev(EvVolt, 16'h1234);
    send_word(5'b00001, 16'h1234, 1'b0, 1'b0);
    send_word(5'b00001, 16'h1234, 1'b0, 1'b0);
    settle("volt_burst");
    checks++;
    if (volt !== 16'h1234) $display("FAIL volt_value: got %h, required %h", volt, 16'h1234);
    else passed++;
  endtask

  task automatic test_parity();
    push_ev(EvPar, 16'h0);
    send_word(5'b00010, 16'hC3A5, 1'b1, 1'b0);
    send_word(5'b00010, 16'hC3A5, 1'b0, 1'b0);
    push_ev(EvFre, 16'hC3A5);
    send_word(5'b00010, 16'hC3A5, 1'b0, 1'b0);
    settle("parity_burst");
  endtask

  task automatic test_fault();
    push_ev(EvFault, 16'h0);
    for (int i = 0; i < 6; i++) send_word(5'b00101, 16'hE5E5, 1'b0, 1'b0);
    settle("fault_burst");
    checks++;
    if (fault_flag !== 1'b1) $display("FAIL fault_flag_set: got %b, required 1", fault_flag);
    else passed++;
    fault_clr = 1'b1;
    cycles(1);
    fault_clr = 1'b0;
    cycles(2);
    checks++;
    if (fault_flag !== 1'b0) $display("FAIL fault_flag_clr: got %b, required 0", fault_flag);
    else passed++;
  endtask

  task automatic test_mismatch_and_glitch();
    send_word(5'b00100, 16'hAAAA, 1'b0, 1'b0);
    send_word(5'b00100, 16'h5555, 1'b0, 1'b0);
    rxd = 1'b0;
    cycles(2);
    rxd = 1'b1;
    cycles(40);
    settle("mismatch_glitch");
    checks++;
    if (state !== 16'h0) $display("FAIL state_unchanged: got %h, required 0", state);
    else passed++;
  endtask

  task automatic test_errors();
    push_ev(EvFrame, 16'h0);
    send_word(5'b00001, 16'h0F0F, 1'b0, 1'b1);
    push_ev(EvType, 16'h0);
    send_word(5'b00111, 16'h1111, 1'b0, 1'b0);
    push_ev(EvType, 16'h0);
    send_word(5'b00101, 16'h1234, 1'b0, 1'b0);
    settle("errors");
  endtask

  task automatic test_back_to_back();
    push_ev(EvVolt, 16'h00FF);
    for (int i = 0; i < 3; i++) send_word(5'b00001, 16'h00FF, 1'b0, 1'b0);
    push_ev(EvState, 16'hBEEF);
    for (int i = 0; i < 3; i++) send_word(5'b00100, 16'hBEEF, 1'b0, 1'b0);
    settle("back_to_back");
  endtask

  task automatic test_reset_mid_word();
    rxd = 1'b0;
    cycles(60);
    rst = 1'b1;
    rxd = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    check_quiet("reset_mid_word");
    cycles(100);
    push_ev(EvVolt, 16'h1234);
    for (int i = 0; i < 3; i++) send_word(5'b00001, 16'h1234, 1'b0, 1'b0);
    settle("after_reset");
  endtask

  initial begin
    test_reset();
    test_volt_burst();
    test_parity();
    test_fault();
    test_mismatch_and_glitch();
    test_errors();
    test_back_to_back();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
